wave_display_mc: RTL and testbench

WAVE_DISPLAY_MC -- requirements
Module: wave_display_mc

---
 rtl/wave_display_mc.sv | 170 +++++++++++++++++
 tb/tb_wave_display_mc.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_display_mc.sv
// wave_display_mc: multi-channel oscilloscope trace renderer over a double-buffered sample RAM.
// Two-cycle pixel pipeline: address decode, then per-channel segment hit test and colour select.

module wave_display_lane #(
    parameter int SAMPLE_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                in_area,
    input  logic                first,
    input  logic                new_s,
    input  logic [SAMPLE_W-1:0] trans_y,
    input  logic [SAMPLE_W-1:0] cur,
    output logic                hit
);
    logic [SAMPLE_W-1:0] last_q, prev_q, prev, lo, hi;

    // Both columns of a sample must see the preceding sample, so the value read on the
    // last cycle is promoted to prev only when the sample index advances.
    always_comb begin
        if (first)      prev = cur;
        else if (new_s) prev = last_q;
        else            prev = prev_q;
        lo  = (prev < cur) ? prev : cur;
        hi  = (prev < cur) ? cur : prev;
        hit = en && in_area && (trans_y >= lo) && (trans_y <= hi);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= '0;
            prev_q <= '0;
        end else if (in_area) begin
            last_q <= cur;
            if (new_s) prev_q <= prev;
        end
    end
endmodule

module wave_display_mc #(
    parameter int                   NUM_CH     = 2,
    parameter int                   SAMPLE_W   = 8,
    parameter int                   ADDR_W     = 8,
    parameter logic [10:0]          X_BASE     = 11'd256,
    parameter logic [NUM_CH*24-1:0] CH_COLOR   = {24'hFFFF00, 24'h00FF00},
    parameter logic [23:0]          GRID_COLOR = 24'h404040
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         valid,
    input  logic [10:0]                  x,
    input  logic [9:0]                   y,
    input  logic                         read_index,
    input  logic                         freeze,
    input  logic [NUM_CH-1:0]            ch_en,
    input  logic [NUM_CH*SAMPLE_W-1:0]   read_value,
    output logic [NUM_CH*(ADDR_W+1)-1:0] read_address,
    output logic                         valid_pixel,
    output logic [7:0]                   r,
    output logic [7:0]                   g,
    output logic [7:0]                   b,
    output logic                         frame_index
);
    localparam int                  STAGES = 1;
    localparam int                  AW1    = ADDR_W + 1;
    localparam logic [11:0]         AREA_W = 12'(2 ** AW1);
    localparam logic [SAMPLE_W-1:0] GRID_Y = {1'b1, {(SAMPLE_W-1){1'b0}}};

    typedef struct packed {
        logic [7:0]        yl;
        logic              y9;
        logic              in_area;
        logic [ADDR_W-1:0] s;
        logic              first;
    } st1_t;

    logic [STAGES:0]     vld_pipe;
    st1_t                st1;
    logic [ADDR_W-1:0]   s_last;
    logic [NUM_CH-1:0]   ch_en_q;
    logic [NUM_CH-1:0]   hit;
    logic [10:0]         dx;
    logic                in_area0;
    logic [ADDR_W-1:0]   s0;
    logic [SAMPLE_W-1:0] trans_y;
    logic                new_s;
    logic                lit;
    logic [23:0]         color;

    // The area test runs on the full 11-bit difference before the index is truncated.
    always_comb begin
        dx       = x - X_BASE;
        in_area0 = (x >= X_BASE) && ({1'b0, dx} < AREA_W) && !y[9];
        s0       = dx[ADDR_W:1];
        for (int c = 0; c < NUM_CH; c++)
            read_address[c*AW1 +: AW1] = in_area0 ? {frame_index, s0} : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_index <= 1'b0;
            ch_en_q     <= '0;
        end else if (valid && x == '0 && y == '0 && !freeze) begin
            frame_index <= read_index;
            ch_en_q     <= ch_en;
        end
    end

    assign vld_pipe[0] = valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe[STAGES:1] <= '0;
            st1                <= '0;
            s_last             <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            st1                <= '{yl: y[8:1], y9: y[9], in_area: in_area0, s: s0, first: (s0 == '0)};
            s_last             <= st1.s;
        end
    end

    assign trans_y = SAMPLE_W'(st1.yl);
    assign new_s   = st1.in_area && (st1.s != s_last);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        wave_display_lane #(.SAMPLE_W(SAMPLE_W)) u_lane (
            .clk     (clk),
            .reset   (reset),
            .en      (ch_en_q[c]),
            .in_area (st1.in_area),
            .first   (st1.first),
            .new_s   (new_s),
            .trans_y (trans_y),
            .cur     (read_value[c*SAMPLE_W +: SAMPLE_W]),
            .hit     (hit[c])
        );
    end

    // Walk from the top channel down so the lowest-numbered hit wins.
    always_comb begin
        lit   = 1'b0;
        color = '0;
        for (int c = NUM_CH-1; c >= 0; c--) begin
            if (hit[c]) begin
                lit   = 1'b1;
                color = CH_COLOR[c*24 +: 24];
            end
        end
        if (!lit && st1.in_area && trans_y == GRID_Y) begin
            lit   = 1'b1;
            color = GRID_COLOR;
        end
        if (!vld_pipe[STAGES] || st1.y9) begin
            lit   = 1'b0;
            color = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_pixel <= 1'b0;
            {r, g, b}   <= '0;
        end else begin
            valid_pixel <= lit;
            {r, g, b}   <= color;
        end
    end
endmodule

// File: tb/tb_wave_display_mc.sv
// Randomised raster scans of wave_display_mc against a behavioural model of the trace rules,
// plus directed scenes pinned to hand-derived pixel values.
module tb_wave_display_mc;
    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [10:0] x;
    logic [9:0]  y;
    logic        read_index;
    logic        freeze;
    logic [1:0]  ch_en;
    logic [15:0] read_value = '0;
    logic [17:0] read_address;
    logic        valid_pixel;
    logic [7:0]  r, g, b;
    logic        frame_index;

    wave_display_mc dut (
        .clk          (clk),
        .reset        (reset),
        .valid        (valid),
        .x            (x),
        .y            (y),
        .read_index   (read_index),
        .freeze       (freeze),
        .ch_en        (ch_en),
        .read_value   (read_value),
        .read_address (read_address),
        .valid_pixel  (valid_pixel),
        .r            (r),
        .g            (g),
        .b            (b),
        .frame_index  (frame_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          xi;
        logic        vp;
        logic [23:0] rgb;
    } exp_t;

    logic [7:0]  mem [0:1][0:1][0:255];   // channel, buffer, index
    exp_t        q [$];
    logic        got_vp  [0:2047];
    logic [23:0] got_rgb [0:2047];
    logic        m_fi;
    logic [1:0]  m_en;
    logic        nxt_ri, nxt_fz;
    logic [1:0]  nxt_en;
    int          n_tests = 0;
    int          n_fail  = 0;

    // Synchronous sample RAM: data one cycle after the address.
    always @(posedge clk) begin
        for (int c = 0; c < 2; c++)
            read_value[c*8 +: 8] <= mem[c][read_address[c*9+8]][read_address[c*9 +: 8]];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // A scan is a contiguous raster, so the previous sample is simply index s-1.
    function automatic void model(input int xi, input int yi, input logic v,
                                  output logic vp, output logic [23:0] rgb);
        int s, ty, cur, prv, lo, hi;
        vp  = 1'b0;
        rgb = '0;
        if (!v || xi < 256 || xi >= 768 || yi >= 512) return;
        s  = (xi - 256) / 2;
        ty = (yi / 2) % 256;
        for (int c = 0; c < 2; c++) begin
            if (m_en[c] && !vp) begin
                cur = mem[c][m_fi][s];
                prv = (s == 0) ? cur : int'(mem[c][m_fi][s-1]);
                lo  = (prv < cur) ? prv : cur;
                hi  = (prv < cur) ? cur : prv;
                if (ty >= lo && ty <= hi) begin
                    vp  = 1'b1;
                    rgb = (c == 0) ? 24'h00FF00 : 24'hFFFF00;
                end
            end
        end
        if (!vp && ty == 128) begin
            vp  = 1'b1;
            rgb = 24'h404040;
        end
    endfunction

    task automatic drive(input int xi, input int yi, input logic v);
        exp_t       e;
        logic [8:0] a;
        @(negedge clk);
        x          = 11'(xi);
        y          = 10'(yi);
        valid      = v;
        read_index = nxt_ri;
        freeze     = nxt_fz;
        ch_en      = nxt_en;
        model(xi, yi, v, e.vp, e.rgb);
        e.xi = xi;
        q.push_back(e);
        a = (xi >= 256 && xi < 768 && yi < 512) ? {m_fi, 8'((xi - 256) / 2)} : 9'd0;
        if (v && xi == 0 && yi == 0 && !nxt_fz) begin
            m_fi = nxt_ri;
            m_en = nxt_en;
        end
        #1;
        check("read_address", 32'(read_address), 32'({a, a}));
    endtask

    task automatic idle2();
        drive(0, 600, 1'b0);
        drive(0, 600, 1'b0);
    endtask

    task automatic scan(input int yi, input int pct_invalid);
        for (int xi = 250; xi <= 775; xi++)
            drive(xi, yi, 1'($urandom_range(99) >= pct_invalid));
        idle2();
    endtask

    task automatic frame(input logic ri, input logic fz, input logic [1:0] en);
        nxt_ri = ri;
        nxt_fz = fz;
        nxt_en = en;
        drive(0, 0, 1'b1);
        idle2();
    endtask

    task automatic fill(input int c, input int bf, input int val);
        for (int i = 0; i < 256; i++) mem[c][bf][i] = 8'(val);
    endtask

    // Compare process: one pixel result per cycle, two cycles behind its inputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset && q.size() >= 2) begin
                e = q.pop_front();
                check("pixel_valid", 32'(valid_pixel), 32'(e.vp));
                check("pixel_rgb", 32'({r, g, b}), 32'(e.rgb));
                if (e.xi >= 0 && e.xi < 2048) begin
                    got_vp[e.xi]  = valid_pixel;
                    got_rgb[e.xi] = {r, g, b};
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; valid = 1'b0; x = '0; y = '0;
        read_index = 1'b0; freeze = 1'b0; ch_en = '0;
        nxt_ri = 1'b0; nxt_fz = 1'b0; nxt_en = '0;
        m_fi = 1'b0; m_en = '0;
        for (int c = 0; c < 2; c++) for (int bf = 0; bf < 2; bf++) fill(c, bf, 0);
        repeat (3) @(negedge clk);
        check("reset_vp", 32'(valid_pixel), 32'd0);
        check("reset_rgb", 32'({r, g, b}), 32'd0);
        check("reset_fi", 32'(frame_index), 32'd0);
        reset = 1'b1;

        // First frame after reset latches buffer 1.
        frame(1'b1, 1'b0, 2'b11);
        check("first_frame_fi", 32'(frame_index), 32'd1);
        drive(256, 0, 1'b1);
        check("addr_x256", 32'(read_address[8:0]), 32'h100);
        idle2();

        // Flat line at 100 on both channels, only channel 0 shown.
        for (int c = 0; c < 2; c++) for (int bf = 0; bf < 2; bf++) fill(c, bf, 100);
        frame(1'b1, 1'b0, 2'b01);
        scan(200, 0);
        check("flat_vp_300", 32'(got_vp[300]), 32'd1);
        check("flat_rgb_300", 32'(got_rgb[300]), 32'h00FF00);
        check("flat_vp_256", 32'(got_vp[256]), 32'd1);
        check("flat_vp_255", 32'(got_vp[255]), 32'd0);
        check("flat_vp_768", 32'(got_vp[768]), 32'd0);
        scan(202, 0);
        check("flat_off_vp_300", 32'(got_vp[300]), 32'd0);

        // Rising step 10 -> 20 between indices 10 and 11.
        for (int i = 0; i < 256; i++) mem[0][1][i] = (i <= 10) ? 8'd10 : 8'd20;
        for (int ty = 9; ty <= 21; ty++) begin
            scan(2 * ty, 0);
            check("rise_s11a", 32'(got_vp[278]), 32'(ty >= 10 && ty <= 20));
            check("rise_s11b", 32'(got_vp[279]), 32'(ty >= 10 && ty <= 20));
            check("rise_s10", 32'(got_vp[276]), 32'(ty == 10));
            check("rise_s12", 32'(got_vp[280]), 32'(ty == 20));
        end

        // Priority and centre line.
        for (int c = 0; c < 2; c++) fill(c, 1, 50);
        frame(1'b1, 1'b0, 2'b11);
        scan(100, 0);
        check("prio_both", 32'(got_rgb[400]), 32'h00FF00);
        frame(1'b1, 1'b0, 2'b10);
        scan(100, 0);
        check("prio_ch1", 32'(got_rgb[400]), 32'hFFFF00);
        scan(256, 0);
        check("grid_vp", 32'(got_vp[400]), 32'd1);
        check("grid_rgb", 32'(got_rgb[400]), 32'h404040);
        check("grid_out_255", 32'(got_vp[255]), 32'd0);

        // Freeze holds the buffer index across a frame start.
        frame(1'b0, 1'b0, 2'b01);
        check("frz_base_fi", 32'(frame_index), 32'd0);
        frame(1'b1, 1'b1, 2'b11);
        check("frz_hold_fi", 32'(frame_index), 32'd0);
        frame(1'b1, 1'b0, 2'b01);
        check("frz_release_fi", 32'(frame_index), 32'd1);

        // Left edge: index 0 draws only its own point.
        mem[0][1][0] = 8'd10;
        mem[0][1][1] = 8'd200;
        scan(100, 0);
        check("edge_s0a", 32'(got_vp[256]), 32'd0);
        check("edge_s0b", 32'(got_vp[257]), 32'd0);
        check("edge_s1", 32'(got_vp[258]), 32'd1);

        // Asynchronous reset in the middle of a lit line.
        fill(0, 1, 100);
        for (int xi = 250; xi <= 301; xi++) drive(xi, 200, 1'b1);
        check("pre_reset_vp", 32'(valid_pixel), 32'd1);
        #2;
        reset = 1'b0;
        q.delete();
        #1;
        check("async_rst_vp", 32'(valid_pixel), 32'd0);
        check("async_rst_rgb", 32'({r, g, b}), 32'd0);
        check("async_rst_fi", 32'(frame_index), 32'd0);
        m_fi = 1'b0;
        m_en = '0;
        @(negedge clk);
        reset = 1'b1;
        fill(0, 0, 100);
        scan(200, 0);
        check("post_reset_dark", 32'(got_vp[300]), 32'd0);

        // Random frames, buffers, masks and rows; inputs also wander mid-frame.
        for (int f = 0; f < 8; f++) begin
            for (int c = 0; c < 2; c++) for (int bf = 0; bf < 2; bf++)
                for (int i = 0; i < 256; i++) mem[c][bf][i] = 8'($urandom_range(60, 200));
            frame(1'($urandom), 1'($urandom_range(3) == 0), 2'($urandom));
            for (int l = 0; l < 5; l++) begin
                nxt_ri = 1'($urandom);
                nxt_fz = 1'($urandom);
                nxt_en = 2'($urandom);
                if ($urandom_range(1) == 1) mem[$urandom_range(1)][m_fi][$urandom_range(255)] = 8'($urandom);
                scan(($urandom_range(4) == 0) ? int'($urandom_range(512, 1023)) : int'($urandom_range(100, 420)), 10);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
